// File: rtl/mem_arbiter_pkg.sv
// Shared command encodings, FSM states and port typedefs for the memory-bus arbiter.
package mem_pkg;

    localparam logic [1:0] MNONE  = 2'b00;
    localparam logic [1:0] MWRITE = 2'b01;
    localparam logic [1:0] MREAD  = 2'b11;

    // Wide enough for LOCK_MAX up to 15.
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef logic port_t;

    function automatic logic is_mem_cmd(input logic [1:0] cmd);
        return (cmd == MREAD) || (cmd == MWRITE);
    endfunction

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// Combinational winner selection: round-robin between two ports with a bounded lock.
module arb_pick
    import mem_pkg::*;
#(
    parameter int LOCK_MAX = 4
) (
    input  logic [1:0]       req,
    input  logic [1:0]       lock,
    input  port_t            last_owner,
    input  logic [CNT_W-1:0] lock_cnt,
    output logic             any_req,
    output port_t            winner,
    output logic [CNT_W-1:0] next_cnt
);

    localparam logic [CNT_W-1:0] LOCK_LIM = CNT_W'(LOCK_MAX);

    logic hold;

    always_comb begin
        any_req  = |req;
        hold     = req[last_owner] && lock[last_owner] && (lock_cnt < LOCK_LIM);
        winner   = 1'b0;
        next_cnt = {{(CNT_W-1){1'b0}}, 1'b1};

        if (req[0] && req[1]) begin
            winner = hold ? last_owner : ~last_owner;
        end else begin
            winner = req[1];
        end

        // Back-to-back grants to a locking owner count up and saturate; anything else restarts at 1.
        if ((winner == last_owner) && lock[winner]) begin
            next_cnt = (lock_cnt < LOCK_LIM) ? lock_cnt + 1'b1 : LOCK_LIM;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port memory-bus arbiter: IDLE picks and latches a transfer, ACCESS drives the bus,
// RESP returns a one-cycle done with registered read data.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 9,
    parameter int LOCK_MAX   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  req1,
    input  logic [1:0]            cmd0,
    input  logic [1:0]            cmd1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    input  logic                  lock0,
    input  logic                  lock1,
    output logic                  done0,
    output logic                  done1,
    output logic [DATA_WIDTH-1:0] rdata0,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic [1:0]            mem_cmd,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    state_t                state, state_nxt;
    port_t                 last_owner;
    logic [CNT_W-1:0]      lock_cnt;

    logic                  any_req;
    port_t                 winner;
    logic [CNT_W-1:0]      next_cnt;

    port_t                 owner_p0;
    logic [1:0]            cmd_p0;
    logic [ADDR_WIDTH-1:0] addr_p0;
    logic [DATA_WIDTH-1:0] wdata_p0;

    arb_pick #(
        .LOCK_MAX (LOCK_MAX)
    ) u_pick (
        .req        ({req1, req0}),
        .lock       ({lock1, lock0}),
        .last_owner (last_owner),
        .lock_cnt   (lock_cnt),
        .any_req    (any_req),
        .winner     (winner),
        .next_cnt   (next_cnt)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = ACCESS;
            ACCESS:  state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // IDLE -> ACCESS: latch the winning transfer and update round-robin/lock history
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_p0   <= 1'b0;
            last_owner <= 1'b1;
            lock_cnt   <= '0;
            cmd_p0     <= MNONE;
            addr_p0    <= '0;
            wdata_p0   <= '0;
        end else if ((state == IDLE) && any_req) begin
            owner_p0   <= winner;
            last_owner <= winner;
            lock_cnt   <= next_cnt;
            cmd_p0     <= winner ? cmd1   : cmd0;
            addr_p0    <= winner ? addr1  : addr0;
            wdata_p0   <= winner ? wdata1 : wdata0;
        end
    end

    // ACCESS -> RESP: capture read data for the owning port
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata0 <= '0;
            rdata1 <= '0;
        end else if ((state == ACCESS) && (cmd_p0 == MREAD)) begin
            if (owner_p0) begin
                rdata1 <= mem_rdata;
            end else begin
                rdata0 <= mem_rdata;
            end
        end
    end

    always_comb begin
        mem_cmd = MNONE;
        if ((state == ACCESS) && is_mem_cmd(cmd_p0)) begin
            mem_cmd = cmd_p0;
        end
    end

    assign mem_addr  = addr_p0;
    assign mem_wdata = wdata_p0;
    assign done0     = (state == RESP) && !owner_p0;
    assign done1     = (state == RESP) &&  owner_p0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected bus/done events, a monitor pops and compares.
module tb_mem_arbiter;
    import mem_pkg::*;

    logic        clk;
    logic        reset;
    logic        req0, req1, lock0, lock1;
    logic [1:0]  cmd0, cmd1;
    logic [8:0]  addr0, addr1;
    logic [15:0] wdata0, wdata1;
    logic        done0, done1;
    logic [15:0] rdata0, rdata1;
    logic [1:0]  mem_cmd;
    logic [8:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;

    mem_arbiter #(.DATA_WIDTH(16), .ADDR_WIDTH(9), .LOCK_MAX(4)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .cmd0(cmd0), .cmd1(cmd1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .lock0(lock0), .lock1(lock1), .done0(done0), .done1(done1),
        .rdata0(rdata0), .rdata1(rdata1),
        .mem_cmd(mem_cmd), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    // Memory decode model: RAM below 0x100, switches/LEDs at 0x100 and up.
    logic [15:0] ram [256];
    logic [7:0]  ledr;
    localparam logic [15:0] SW_VAL = 16'h005A;

    assign mem_rdata = mem_addr[8] ? SW_VAL : ram[mem_addr[7:0]];

    always @(posedge clk) begin
        if (mem_cmd == MWRITE) begin
            if (mem_addr[8]) ledr <= mem_wdata[7:0];
            else             ram[mem_addr[7:0]] <= mem_wdata;
        end
    end

    typedef struct { int port; logic [15:0] rdata; int cyc; } done_exp_t;
    typedef struct { logic [1:0] cmd; logic [8:0] addr; logic [15:0] wdata; int cyc; } mem_exp_t;

    done_exp_t done_q[$];
    mem_exp_t  mem_q[$];

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name);
        tests++;
        fails++;
        $display("FAIL %s: unexpected event at cycle %0d", name, cyc);
    endtask

    always @(negedge clk) begin
        if (mem_cmd != MNONE) begin
            if (mem_q.size() == 0) begin
                flag("mem_unexpected");
            end else begin
                mem_exp_t m;
                m = mem_q.pop_front();
                check("mem_cmd",   32'(mem_cmd),   32'(m.cmd));
                check("mem_addr",  32'(mem_addr),  32'(m.addr));
                check("mem_wdata", 32'(mem_wdata), 32'(m.wdata));
                check("mem_cycle", 32'(cyc),       32'(m.cyc));
            end
        end
        if (done0 && done1) begin
            flag("done_both");
        end else if (done0 || done1) begin
            if (done_q.size() == 0) begin
                flag("done_unexpected");
            end else begin
                done_exp_t d;
                d = done_q.pop_front();
                check("done_port",  done1 ? 32'd1 : 32'd0, 32'(d.port));
                check("done_rdata", done1 ? 32'(rdata1) : 32'(rdata0), 32'(d.rdata));
                check("done_cycle", 32'(cyc), 32'(d.cyc));
            end
        end
    end

    task automatic push_mem(input logic [1:0] c, input logic [8:0] a, input logic [15:0] w, input int at);
        mem_exp_t m;
        m.cmd = c; m.addr = a; m.wdata = w; m.cyc = at;
        if (is_mem_cmd(c)) mem_q.push_back(m);
    endtask

    task automatic push_done(input int p, input logic [15:0] rd, input int at);
        done_exp_t d;
        d.port = p; d.rdata = rd; d.cyc = at;
        done_q.push_back(d);
    endtask

    // Entered and left at a negedge with the arbiter in IDLE.
    task automatic single(input int p, input logic [1:0] c, input logic [8:0] a,
                          input logic [15:0] w, input logic [15:0] exp_rd);
        int n;
        if (p == 1) begin req1 = 1'b1; cmd1 = c; addr1 = a; wdata1 = w; end
        else        begin req0 = 1'b1; cmd0 = c; addr0 = a; wdata0 = w; end
        n = cyc;
        push_mem(c, a, w, n + 1);
        push_done(p, exp_rd, n + 2);
        repeat (2) @(negedge clk);
        req0 = 1'b0;
        req1 = 1'b0;
        @(negedge clk);
    endtask

    // Both ports hold their transfers; order bit i gives the port granted i-th.
    task automatic run_both(input int ngr, input logic [15:0] order,
                            input logic [15:0] rd0, input logic [15:0] rd1);
        int n;
        req0 = 1'b1;
        req1 = 1'b1;
        n = cyc;
        for (int i = 0; i < ngr; i++) begin
            if (order[i]) begin
                push_mem(cmd1, addr1, wdata1, n + 1 + 3 * i);
                push_done(1, rd1, n + 2 + 3 * i);
            end else begin
                push_mem(cmd0, addr0, wdata0, n + 1 + 3 * i);
                push_done(0, rd0, n + 2 + 3 * i);
            end
        end
        repeat (3 * ngr - 1) @(negedge clk);
        req0 = 1'b0;
        req1 = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 16'h0000;
        ram[5] = 16'hBEEF;
        ledr   = 8'h00;
        req0 = 0; req1 = 0; lock0 = 0; lock1 = 0;
        cmd0 = MNONE; cmd1 = MNONE; addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        reset = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_mem_cmd",   32'(mem_cmd),   32'h0);
        check("rst_mem_addr",  32'(mem_addr),  32'h0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'h0);
        check("rst_done0",     32'(done0),     32'h0);
        check("rst_done1",     32'(done1),     32'h0);
        check("rst_rdata0",    32'(rdata0),    32'h0);
        check("rst_rdata1",    32'(rdata1),    32'h0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        single(0, MREAD, 9'h005, 16'h0000, 16'hBEEF);
        check("rdata0_held", 32'(rdata0), 32'hBEEF);

        single(1, MWRITE, 9'h100, 16'h00A5, 16'h0000);
        check("ledr_after_write", 32'(ledr), 32'h00A5);

        cmd0 = MWRITE; addr0 = 9'h010; wdata0 = 16'h1111;
        cmd1 = MWRITE; addr1 = 9'h020; wdata1 = 16'h2222;
        run_both(4, 16'b1010, 16'hBEEF, 16'h0000);

        single(1, MREAD, 9'h010, 16'h0000, 16'h1111);
        single(0, MREAD, 9'h020, 16'h0000, 16'h2222);

        single(0, 2'b10, 9'h005, 16'h0000, 16'h2222);
        check("noop_rdata0", 32'(rdata0), 32'h2222);

        // Abort a read while it is on the bus.
        req0 = 1'b1; cmd0 = MREAD; addr0 = 9'h020; wdata0 = 16'h0000;
        push_mem(MREAD, 9'h020, 16'h0000, cyc + 1);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("abort_mem_cmd", 32'(mem_cmd), 32'h0);
        check("abort_done0",   32'(done0),   32'h0);
        check("abort_rdata0",  32'(rdata0),  32'h0);
        req0 = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        check("post_abort_mem_cmd", 32'(mem_cmd), 32'h0);

        cmd0 = MWRITE; addr0 = 9'h030; wdata0 = 16'h3333;
        cmd1 = MWRITE; addr1 = 9'h040; wdata1 = 16'h4444;
        lock1 = 1'b1;
        run_both(7, 16'b1101111, 16'h0000, 16'h0000);
        lock1 = 1'b0;

        single(0, MREAD, 9'h040, 16'h0000, 16'h4444);

        repeat (3) @(negedge clk);
        check("done_queue_empty", 32'(done_q.size()), 32'h0);
        check("mem_queue_empty",  32'(mem_q.size()),  32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
